// File: rtl/svc_rv_dmem_model.sv
// svc_rv_dmem_model: byte-strobed word memory responder for the svc_rv core's dmem port.
// Latency: read 0 cycles (MEM_TYPE=0) or 1 cycle (MEM_TYPE=1); writes commit on the accepting edge.
// Backpressure: LFSR-driven dmem_stall, at most STALL_MAX consecutive cycles. Macro SVC_RV_DMEM_WR_FWD_EN enables write-first forwarding.
module svc_rv_dmem_model #(
  parameter int          AW        = 10,
  parameter int          MEM_TYPE  = 1,
  parameter int          STALL_MAX = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dmem_ren,
  input  logic [31:0] dmem_raddr,
  output logic [31:0] dmem_rdata,
  input  logic        dmem_we,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_stall,
  input  logic        stall_en,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [31:0] stall_count
);

  localparam int          DEPTH       = 1 << AW;
  localparam logic [1:0]  STALL_MAX_L = 2'(STALL_MAX);
  // Galois feedback mask for x^16+x^14+x^13+x^11+1 (right-shifting form).
  localparam logic [15:0] LFSR_TAPS   = 16'hB400;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] ridx;
  logic [AW-1:0] widx;
  logic [31:0]   mem_word;
  logic [31:0]   rd_word;
  logic          rd_acc;
  logic          wr_acc;

  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  run_q, run_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [31:0] st_cnt_q, st_cnt_d;

  // Byte offset and high address bits are don't-care: addresses alias modulo the depth.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{dmem_raddr[31:AW+2], dmem_raddr[1:0],
                              dmem_waddr[31:AW+2], dmem_waddr[1:0]};

  assign ridx     = dmem_raddr[AW+1:2];
  assign widx     = dmem_waddr[AW+1:2];
  assign mem_word = mem[ridx];

  // Stall only on a live request, bounded by the run counter so the initiator always progresses.
  assign dmem_stall = !reset && stall_en && (dmem_ren || dmem_we) && lfsr_q[0] && (run_q < STALL_MAX_L);
  assign rd_acc     = dmem_ren && !dmem_stall && !reset;
  assign wr_acc     = dmem_we && !dmem_stall && !reset;

`ifdef SVC_RV_DMEM_WR_FWD_EN
  // Write-first merge: strobed bytes of a same-cycle same-word write override stored data.
  always_comb begin
    rd_word = mem_word;
    if (rd_acc && wr_acc && (ridx == widx)) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_wstrb[b]) rd_word[8*b +: 8] = dmem_wdata[8*b +: 8];
      end
    end
  end
`else
  assign rd_word = mem_word;
`endif

  // Next-state for LFSR, stall run length, registered read data and counters.
  always_comb begin
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0);
    run_d    = dmem_stall ? run_q + 2'd1 : 2'd0;
    rdata_d  = rd_acc ? rd_word : rdata_q;
    rd_cnt_d = rd_acc ? rd_cnt_q + 32'd1 : rd_cnt_q;
    wr_cnt_d = wr_acc ? wr_cnt_q + 32'd1 : wr_cnt_q;
    st_cnt_d = dmem_stall ? st_cnt_q + 32'd1 : st_cnt_q;
  end

  // Control and status state with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_q   <= LFSR_SEED;
      run_q    <= 2'd0;
      rdata_q  <= 32'h0;
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
      st_cnt_q <= 32'h0;
    end else begin
      lfsr_q   <= lfsr_d;
      run_q    <= run_d;
      rdata_q  <= rdata_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  // Storage write: only strobed bytes change; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (dmem_wstrb[b]) mem[widx][8*b +: 8] <= dmem_wdata[8*b +: 8];
      end
    end
  end

  generate
    if (MEM_TYPE == 0) begin : g_sram
      assign dmem_rdata = dmem_ren ? rd_word : 32'h0;
    end else begin : g_bram
      assign dmem_rdata = rdata_q;
    end
  endgenerate

  assign rd_count    = rd_cnt_q;
  assign wr_count    = wr_cnt_q;
  assign stall_count = st_cnt_q;

endmodule

// File: tb/tb_svc_rv_dmem_model.sv
// Directed bench for svc_rv_dmem_model in its default build (MEM_TYPE=1, STALL_MAX=2, AW=10).
// Inputs change 1 time unit after the rising edge; outputs are sampled then or at the falling edge.
// Summary line reports compared / mismatched counts.
module tb_svc_rv_dmem_model;

  localparam int STALL_MAX = 2;

  logic        clock;
  logic        reset;
  logic        dmem_ren;
  logic [31:0] dmem_raddr;
  logic [31:0] dmem_rdata;
  logic        dmem_we;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_stall;
  logic        stall_en;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic [31:0] stall_count;

  int          n_cmp;
  int          n_err;
  logic [31:0] exp_rd;
  logic [31:0] exp_wr;
  logic [31:0] rdat;

  svc_rv_dmem_model #(
    .AW(10), .MEM_TYPE(1), .STALL_MAX(STALL_MAX), .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clock), .reset(reset),
    .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata),
    .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_stall(dmem_stall), .stall_en(stall_en),
    .rd_count(rd_count), .wr_count(wr_count), .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One write cycle with stall_en=0 (always accepted).
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    dmem_we = 1'b1; dmem_waddr = a; dmem_wdata = d; dmem_wstrb = s;
    @(posedge clock); #1;
    dmem_we = 1'b0;
    exp_wr++;
  endtask

  // One read cycle with stall_en=0; registered data is visible after the edge.
  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    dmem_ren = 1'b1; dmem_raddr = a;
    @(posedge clock); #1;
    dmem_ren = 1'b0;
    d = dmem_rdata;
    exp_rd++;
  endtask

  initial begin
    int          nstall, run, max_run, rdata_err, idle_stalls;
    logic        s, prev_s, sel, got;
    logic [31:0] r, prev_r, prev_exp;

    n_cmp = 0; n_err = 0; exp_rd = 0; exp_wr = 0;
    reset = 1'b1; stall_en = 1'b1; dmem_ren = 1'b1; dmem_we = 1'b0;
    dmem_raddr = 32'h0; dmem_waddr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;

    // Stall forced low during reset even with a request and stall_en.
    #2;
    check_eq("stall_during_reset", 32'(dmem_stall), 32'd0);
    @(posedge clock); #1;
    dmem_ren = 1'b0; stall_en = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check_eq("rst_rdata", dmem_rdata, 32'h0);
    check_eq("rst_rd_count", rd_count, 32'd0);
    check_eq("rst_wr_count", wr_count, 32'd0);
    check_eq("rst_stall_count", stall_count, 32'd0);

    // Full write then read.
    wr(32'h100, 32'hDEADBEEF, 4'hF);
    rd(32'h100, rdat);
    check_eq("wr_rd_data", rdat, 32'hDEADBEEF);
    check_eq("wr_rd_rd_count", rd_count, 32'd1);
    check_eq("wr_rd_wr_count", wr_count, 32'd1);

    // Read data holds through an idle cycle.
    @(posedge clock); #1;
    check_eq("rdata_hold_idle", dmem_rdata, 32'hDEADBEEF);

    // Partial write with strobe 0101.
    wr(32'h40, 32'h11223344, 4'hF);
    wr(32'h40, 32'hAABBCCDD, 4'b0101);
    rd(32'h40, rdat);
    check_eq("partial_write", rdat, 32'h11BB33DD);

    // Address aliasing modulo 4 KiB, byte offset ignored.
    wr(32'h0, 32'h0, 4'hF);
    wr(32'h1000, 32'h00000055, 4'h1);
    rd(32'h0, rdat);
    check_eq("alias_0x0", rdat, 32'h00000055);
    rd(32'h3, rdat);
    check_eq("alias_0x3", rdat, 32'h00000055);

    // Zero-strobe write is counted but leaves storage alone.
    wr(32'h100, 32'h0, 4'h0);
    rd(32'h100, rdat);
    check_eq("wstrb0_data", rdat, 32'hDEADBEEF);
    check_eq("wstrb0_wr_count", wr_count, exp_wr);

    // Same-cycle read and write to one word.
    wr(32'h20, 32'h0, 4'hF);
    dmem_ren = 1'b1; dmem_raddr = 32'h20;
    dmem_we = 1'b1; dmem_waddr = 32'h20; dmem_wdata = 32'hCAFEF00D; dmem_wstrb = 4'hF;
    @(posedge clock); #1;
    dmem_ren = 1'b0; dmem_we = 1'b0;
    exp_rd++; exp_wr++;
`ifdef SVC_RV_DMEM_WR_FWD_EN
    check_eq("raw_same_cycle", dmem_rdata, 32'hCAFEF00D);
`else
    check_eq("raw_same_cycle", dmem_rdata, 32'h0);
`endif
    rd(32'h20, rdat);
    check_eq("raw_after", rdat, 32'hCAFEF00D);
    check_eq("counts_rd", rd_count, exp_rd);

    // No stall without a request.
    stall_en = 1'b1;
    idle_stalls = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (dmem_stall) idle_stalls++;
    end
    @(posedge clock); #1;
    check_eq("idle_no_stall", 32'(idle_stalls), 32'd0);

    // 200 cycles of continuous read requests alternating two addresses on each accept.
    sel = 1'b0; dmem_raddr = 32'h100; dmem_ren = 1'b1;
    nstall = 0; run = 0; max_run = 0; rdata_err = 0;
    prev_s = 1'b0; prev_r = 32'h0; prev_exp = 32'h0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      s = dmem_stall; r = dmem_rdata;
      if (i > 0) begin
        if (prev_s) begin
          if (r !== prev_r) rdata_err++;
        end else if (r !== prev_exp) begin
          rdata_err++;
        end
      end
      if (s) begin
        nstall++; run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      prev_s = s; prev_r = r;
      prev_exp = sel ? 32'h11BB33DD : 32'hDEADBEEF;
      @(posedge clock); #1;
      if (!s) begin
        sel = ~sel;
        dmem_raddr = sel ? 32'h40 : 32'h100;
      end
    end
    dmem_ren = 1'b0; stall_en = 1'b0;
    check_eq("stall_run_bound", 32'(max_run <= STALL_MAX), 32'd1);
    check_eq("stalls_seen", 32'(nstall > 0), 32'd1);
    check_eq("rdata_during_stall", 32'(rdata_err), 32'd0);
    exp_rd = exp_rd + 32'(200 - nstall);
    check_eq("stall_rd_count", rd_count, exp_rd);
    check_eq("stall_count", stall_count, 32'(nstall));

    // Reset while stalled with a write pending.
    wr(32'h80, 32'h0BADCAFE, 4'hF);
    stall_en = 1'b1; dmem_ren = 1'b1; dmem_raddr = 32'h100;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      if (dmem_stall) got = 1'b1;
      else begin
        @(posedge clock); #1;
      end
    end
    check_eq("stall_seen_before_reset", 32'(got), 32'd1);
    reset = 1'b1;
    dmem_we = 1'b1; dmem_waddr = 32'h80; dmem_wdata = 32'h00001234; dmem_wstrb = 4'hF;
    #1;
    check_eq("stall_low_in_reset", 32'(dmem_stall), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; dmem_we = 1'b0; dmem_ren = 1'b0; stall_en = 1'b0;
    exp_rd = 0; exp_wr = 0;
    check_eq("midrst_rdata", dmem_rdata, 32'h0);
    check_eq("midrst_rd_count", rd_count, 32'd0);
    check_eq("midrst_wr_count", wr_count, 32'd0);
    check_eq("midrst_stall_count", stall_count, 32'd0);
    rd(32'h80, rdat);
    check_eq("midrst_mem_unchanged", rdat, 32'h0BADCAFE);
    check_eq("midrst_rd_after", rd_count, exp_rd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/svc_rv_dmem_model.md
Name: svc_rv_dmem_model

Overview:
- Synthesizable data-memory responder for the svc_rv core's dmem initiator port: dmem_ren/raddr/rdata, dmem_we/waddr/wdata/wstrb, dmem_stall.
- Provides byte-strobed word storage, SRAM (0-cycle) or BRAM (1-cycle) read timing, and bounded pseudo-random stall injection.
- Used by simulation benches and SoC bring-up in place of a plain BRAM, to exercise the core's stall and load-use paths with real data.

Parameters:
- AW, 10: word-address width; depth is 2^AW words.
- MEM_TYPE, 1: 0 = combinational read, 1 = registered read.
- STALL_MAX, 2: maximum consecutive stall cycles, range 1..3.
- LFSR_SEED, 16'hACE1: stall LFSR reset value; must be non-zero.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dmem_ren  in  1  read request
- dmem_raddr  in  32  byte read address
- dmem_rdata  out  32  read data
- dmem_we  in  1  write request
- dmem_waddr  in  32  byte write address
- dmem_wdata  in  32  write data
- dmem_wstrb  in  4  byte write enables; bit i covers wdata[8i+7:8i]
- dmem_stall  out  1  memory not accepting; initiator holds its request
- stall_en  in  1  enable random stall injection
- rd_count  out  32  accepted reads
- wr_count  out  32  accepted writes
- stall_count  out  32  cycles with dmem_stall=1

Behaviour:
- Index: word index = addr[AW+1:2]. Bits [1:0] and bits above AW+1 are ignored, so addresses alias modulo 4*2^AW bytes.
- Memory contents are not cleared by reset.
- Accept conditions:
  - Read accepted when dmem_ren && !dmem_stall.
  - Write accepted when dmem_we && !dmem_stall.
  - Read and write may be accepted in the same cycle.
- Write: on the accepting edge, only bytes with wstrb=1 are updated. wstrb=0 with we=1 is accepted and counted, but storage is unchanged.
- Read, MEM_TYPE=0:
  - dmem_rdata = mem[raddr] combinationally when dmem_ren=1.
  - 0 when dmem_ren=0.
- Read, MEM_TYPE=1:
  - dmem_rdata is registered and loads mem[raddr] on the accepting edge.
  - Otherwise it holds its last value, including through stalls and idle cycles.
  - Reset value is 0.
- Same-word read and write accepted in the same cycle: read-first. The read returns pre-write data for both MEM_TYPE values, unless SVC_RV_DMEM_WR_FWD_EN is defined.
- Stall generator:
  - 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1. Advances every non-reset cycle.
  - run counter (2 bits) counts consecutive stall cycles.
  - dmem_stall = !reset && stall_en && (dmem_ren || dmem_we) && lfsr[0] && (run < STALL_MAX).
  - run increments while dmem_stall=1 and clears to 0 when dmem_stall=0.
  - Forward progress is therefore guaranteed: at most STALL_MAX stalls, then one non-stall cycle.
  - No stall is ever raised without a request.
- stall_en deasserted mid-run: dmem_stall drops to 0 the same cycle, and run clears on the next edge.
- Counters: 32-bit, wrap at 2^32.
  - rd_count increments on read accept.
  - wr_count increments on write accept.
  - stall_count increments on each dmem_stall=1 cycle.
- Reset (sampled on the edge):
  - lfsr = LFSR_SEED, run = 0.
  - rdata register = 0.
  - All counters = 0.
  - dmem_stall forced 0 combinationally during the reset cycle.
  - A write pending during reset is not committed.
- Reset mid-stall: the stall is abandoned; the first post-reset request starts with run=0.

Optional Feature:
- Macro SVC_RV_DMEM_WR_FWD_EN.
- Defined: when read and write are accepted in the same cycle to the same word index, rdata returns write-first data:
  - bytes with wstrb=1 come from dmem_wdata;
  - remaining bytes come from stored data.
  - Applies to both MEM_TYPE values; for MEM_TYPE=1 the merged value is registered.
- Undefined: read-first as above, and no forwarding logic is generated.

Test Plan:
- Write, then read, MEM_TYPE=1, stall_en=0: write 0xDEADBEEF to 0x100 with wstrb=4'hF; read 0x100 next cycle → dmem_rdata=0xDEADBEEF one cycle after ren; rd_count=1, wr_count=1.
- Partial write: mem[0x40]=0x11223344, then write 0xAABBCCDD with wstrb=4'b0101 → read returns 0x11BB33DD.
- Alias: AW=10; write 0x55 with wstrb=4'h1 to 0x1000; read 0x0000 → 0x55 in byte 0; read 0x0003 → same word.
- Stall bound: stall_en=1, continuous ren for 200 cycles →
  - never more than STALL_MAX consecutive stall cycles;
  - rd_count + stall_count = 200;
  - rdata stable during every stall.
- Same-cycle RAW: mem[0x20]=0x0; accept read and write (0xCAFEF00D, wstrb=4'hF) to 0x20 together → 0x0 without the macro, 0xCAFEF00D with SVC_RV_DMEM_WR_FWD_EN.
- Reset mid-stall: assert reset while dmem_stall=1 with a pending write of 0x1234 to 0x80 →
  - dmem_stall=0 during the reset cycle;
  - counters=0 and rdata=0 after reset;
  - mem[0x80] unchanged.
